// File: rtl/bp_cfg_boot_pkg.sv
// Shared state encoding and config register map for the boot sequencer.
package bp_cfg_boot_pkg;

   typedef enum logic [2:0] {
      e_reset,
      e_freeze,
      e_core_id,
      e_cache_mode,
      e_ucode,
      e_unfreeze,
      e_done
   } bp_cfg_boot_state_e;

   localparam logic [15:0] cfg_addr_freeze_gp     = 16'h0002;
   localparam logic [15:0] cfg_addr_core_id_gp    = 16'h0004;
   localparam logic [15:0] cfg_addr_cache_mode_gp = 16'h0006;
   localparam logic [15:0] cfg_addr_ucode_base_gp = 16'h8000;

   localparam int unsigned e_cfg_cache_mode_normal = 1;

endpackage

// File: rtl/bp_cfg_boot_beat_reg.sv
// Registered config-bus beat: valid plus payload, held stable until the endpoint accepts it.
module bp_cfg_boot_beat_reg
   import bp_cfg_boot_pkg::*;
#(
   parameter int unsigned core_id_width_p  = 8,
   parameter int unsigned cfg_addr_width_p = 16,
   parameter int unsigned cfg_data_width_p = 64
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        load_i,
   input  logic                        ready_i,
   input  logic [core_id_width_p-1:0]  core_i,
   input  logic [cfg_addr_width_p-1:0] addr_i,
   input  logic [cfg_data_width_p-1:0] data_i,
   output logic                        v_o,
   output logic [core_id_width_p-1:0]  core_o,
   output logic [cfg_addr_width_p-1:0] addr_o,
   output logic [cfg_data_width_p-1:0] data_o
);

   logic                        v_q, v_d;
   logic [core_id_width_p-1:0]  core_q, core_d;
   logic [cfg_addr_width_p-1:0] addr_q, addr_d;
   logic [cfg_data_width_p-1:0] data_q, data_d;

   // load_i is only raised when the slot is empty or draining this cycle.
   always_comb begin
      v_d    = v_q;
      core_d = core_q;
      addr_d = addr_q;
      data_d = data_q;
      if (load_i) begin
         v_d    = 1'b1;
         core_d = core_i;
         addr_d = addr_i;
         data_d = data_i;
      end else if (ready_i) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         v_q    <= 1'b0;
         core_q <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         v_q    <= v_d;
         core_q <= core_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign v_o    = v_q;
   assign core_o = core_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Post-reset config master: freeze, core id, cache mode, [microcode], unfreeze for every tile.
// Microcode loading is included only when BP_CFG_UCODE_LOAD_EN is defined.
module bp_cfg_boot_sequencer
   import bp_cfg_boot_pkg::*;
#(
   parameter int unsigned num_core_p       = 2,
   parameter int unsigned cfg_addr_width_p = 16,
   parameter int unsigned cfg_data_width_p = 64,
   parameter int unsigned cce_pc_width_p   = 8,
   parameter int unsigned ucode_els_p      = 256,
   parameter int unsigned core_id_width_p  = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic [core_id_width_p-1:0]  cfg_core_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   output logic [cce_pc_width_p-1:0]   ucode_addr_o,
   input  logic [cfg_data_width_p-1:0] ucode_data_i,
   output logic                        done_o
);

   localparam int unsigned core_last_lp  = num_core_p - 1;
   localparam int unsigned ucode_last_lp = ucode_els_p - 1;

   bp_cfg_boot_state_e          state_q, state_d;
   logic [core_id_width_p-1:0]  core_cnt_q, core_cnt_d;
   logic [cce_pc_width_p-1:0]   ucode_cnt_q, ucode_cnt_d;
   logic                        done_q, done_d;
   logic                        load, beat_free, is_write, core_last, ucode_last;
   logic [cfg_addr_width_p-1:0] beat_addr;
   logic [cfg_data_width_p-1:0] beat_data, ucode_word;

`ifdef BP_CFG_UCODE_LOAD_EN
   localparam bp_cfg_boot_state_e after_cache_mode_lp = e_ucode;
   assign ucode_addr_o = ucode_cnt_q;
   assign ucode_word   = ucode_data_i;
`else
   localparam bp_cfg_boot_state_e after_cache_mode_lp = e_unfreeze;
   logic unused_ucode_data;
   assign unused_ucode_data = ^ucode_data_i;
   assign ucode_addr_o      = '0;
   assign ucode_word        = '0;
`endif

   assign beat_free  = ~cfg_v_o | cfg_ready_i;
   assign core_last  = (core_cnt_q == core_id_width_p'(core_last_lp));
   assign ucode_last = (ucode_cnt_q == cce_pc_width_p'(ucode_last_lp));
   assign is_write   = state_q inside {e_freeze, e_core_id, e_cache_mode, e_ucode, e_unfreeze};

   always_comb begin
      state_d     = state_q;
      core_cnt_d  = core_cnt_q;
      ucode_cnt_d = ucode_cnt_q;
      done_d      = done_q;
      load        = 1'b0;
      beat_addr   = '0;
      beat_data   = '0;

      unique case (state_q)
         e_reset: state_d = e_freeze;
         e_freeze: begin
            beat_addr = cfg_addr_width_p'(cfg_addr_freeze_gp);
            beat_data = cfg_data_width_p'(1);
         end
         e_core_id: begin
            beat_addr = cfg_addr_width_p'(cfg_addr_core_id_gp);
            beat_data = cfg_data_width_p'(core_cnt_q);
         end
         e_cache_mode: begin
            beat_addr = cfg_addr_width_p'(cfg_addr_cache_mode_gp);
            beat_data = cfg_data_width_p'(e_cfg_cache_mode_normal);
         end
         e_ucode: begin
            beat_addr = cfg_addr_width_p'(cfg_addr_ucode_base_gp)
                      | cfg_addr_width_p'(ucode_cnt_q);
            beat_data = ucode_word;
         end
         e_unfreeze: begin
            beat_addr = cfg_addr_width_p'(cfg_addr_freeze_gp);
            beat_data = '0;
         end
         // Done only once the final unfreeze beat has drained from the output register.
         e_done: done_d = done_q | beat_free;
         default: state_d = e_reset;
      endcase

      // Counters always point at the next beat to present.
      if (is_write && beat_free) begin
         load = 1'b1;
         if (state_q == e_ucode && !ucode_last) begin
            ucode_cnt_d = ucode_cnt_q + cce_pc_width_p'(1);
         end else begin
            ucode_cnt_d = '0;
            core_cnt_d  = core_last ? '0 : core_cnt_q + core_id_width_p'(1);
            if (core_last) begin
               unique case (state_q)
                  e_freeze:     state_d = e_core_id;
                  e_core_id:    state_d = e_cache_mode;
                  e_cache_mode: state_d = after_cache_mode_lp;
                  e_ucode:      state_d = e_unfreeze;
                  default:      state_d = e_done;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= e_reset;
         core_cnt_q  <= '0;
         ucode_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         core_cnt_q  <= core_cnt_d;
         ucode_cnt_q <= ucode_cnt_d;
         done_q      <= done_d;
      end
   end

   assign done_o = done_q;

   bp_cfg_boot_beat_reg #(
      .core_id_width_p (core_id_width_p),
      .cfg_addr_width_p(cfg_addr_width_p),
      .cfg_data_width_p(cfg_data_width_p)
   ) u_beat_reg (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .load_i   (load),
      .ready_i  (cfg_ready_i),
      .core_i   (core_cnt_q),
      .addr_i   (beat_addr),
      .data_i   (beat_data),
      .v_o      (cfg_v_o),
      .core_o   (cfg_core_o),
      .addr_o   (cfg_addr_o),
      .data_o   (cfg_data_o)
   );

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Bench for bp_cfg_boot_sequencer: two instances (2 tiles x 4 ucode words, 1 tile x 1 word)
// checked against an ordered list of expected config writes.
module tb_bp_cfg_boot_sequencer;

`ifdef BP_CFG_UCODE_LOAD_EN
   localparam bit ucode_on = 1'b1;
`else
   localparam bit ucode_on = 1'b0;
`endif

   typedef struct {
      int          core;
      int          addr;
      logic [63:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n_a, rst_n_b, ready, sel_b;
   logic        v_a, v_b, done_a, done_b;
   logic [7:0]  core_a, core_b, uaddr_a, uaddr_b;
   logic [15:0] addr_a, addr_b;
   logic [63:0] data_a, data_b, udata_a, udata_b;

   logic        o_v, o_done;
   logic [7:0]  o_core, o_uaddr;
   logic [15:0] o_addr;
   logic [63:0] o_data;

   // ROM word k holds 0xA5A5_0000 + k
   assign udata_a = 64'hA5A5_0000 + 64'(uaddr_a);
   assign udata_b = 64'hA5A5_0000 + 64'(uaddr_b);

   assign o_v     = sel_b ? v_b     : v_a;
   assign o_done  = sel_b ? done_b  : done_a;
   assign o_core  = sel_b ? core_b  : core_a;
   assign o_addr  = sel_b ? addr_b  : addr_a;
   assign o_data  = sel_b ? data_b  : data_a;
   assign o_uaddr = sel_b ? uaddr_b : uaddr_a;

   bp_cfg_boot_sequencer #(
      .num_core_p (2),
      .ucode_els_p(4)
   ) u_dut_a (
      .clk_i       (clk),
      .reset_n_i   (rst_n_a),
      .cfg_v_o     (v_a),
      .cfg_ready_i (ready),
      .cfg_core_o  (core_a),
      .cfg_addr_o  (addr_a),
      .cfg_data_o  (data_a),
      .ucode_addr_o(uaddr_a),
      .ucode_data_i(udata_a),
      .done_o      (done_a)
   );

   bp_cfg_boot_sequencer #(
      .num_core_p (1),
      .ucode_els_p(1)
   ) u_dut_b (
      .clk_i       (clk),
      .reset_n_i   (rst_n_b),
      .cfg_v_o     (v_b),
      .cfg_ready_i (ready),
      .cfg_core_o  (core_b),
      .cfg_addr_o  (addr_b),
      .cfg_data_o  (data_b),
      .ucode_addr_o(uaddr_b),
      .ucode_data_i(udata_b),
      .done_o      (done_b)
   );

   int    n_chk = 0;
   int    n_err = 0;
   beat_t exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_beat(input int core, input int addr, input logic [63:0] data);
      beat_t b;
      b.core = core;
      b.addr = addr;
      b.data = data;
      exp_q.push_back(b);
   endtask

   // Full write order for a config: each phase visits every tile before the next phase.
   task automatic build_expected(input int nc, input int ne);
      exp_q.delete();
      for (int c = 0; c < nc; c++) push_beat(c, 'h2, 64'd1);
      for (int c = 0; c < nc; c++) push_beat(c, 'h4, 64'(c));
      for (int c = 0; c < nc; c++) push_beat(c, 'h6, 64'd1);
      if (ucode_on) begin
         for (int c = 0; c < nc; c++) begin
            for (int k = 0; k < ne; k++) push_beat(c, 'h8000 + k, 64'hA5A5_0000 + 64'(k));
         end
      end
      for (int c = 0; c < nc; c++) push_beat(c, 'h2, 64'd0);
   endtask

   // Holds both instances in reset, checks reset outputs, releases the chosen one.
   // Returns one cycle after release, where no beat may be valid yet.
   task automatic reset_dut(input bit b);
      @(negedge clk);
      sel_b   = b;
      ready   = 1'b0;
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_v", 64'(o_v), 64'd0);
      check_eq("rst_done", 64'(o_done), 64'd0);
      check_eq("rst_core", 64'(o_core), 64'd0);
      check_eq("rst_addr", 64'(o_addr), 64'd0);
      check_eq("rst_data", o_data, 64'd0);
      check_eq("rst_uaddr", 64'(o_uaddr), 64'd0);
      if (b) rst_n_b = 1'b1;
      else rst_n_a = 1'b1;
      @(negedge clk);
      check_eq("v_before_first_beat", 64'(o_v), 64'd0);
   endtask

   task automatic stream(input string tag, input int nc, input int ne, input int pct,
                         input bit strict);
      int    cyc = 0;
      int    got = 0;
      int    total;
      beat_t b;
      build_expected(nc, ne);
      total = exp_q.size();
      while (exp_q.size() > 0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         ready = ($urandom_range(99) < pct);
         if (strict) begin
            check_eq({tag, "_v_gap"}, 64'(o_v), 64'd1);
            check_eq({tag, "_done_early"}, 64'(o_done), 64'd0);
         end
         if (o_v && ready) begin
            b = exp_q.pop_front();
            got++;
            check_eq({tag, "_core"}, 64'(o_core), 64'(b.core));
            check_eq({tag, "_addr"}, 64'(o_addr), 64'(b.addr));
            check_eq({tag, "_data"}, o_data, b.data);
         end
      end
      check_eq({tag, "_beat_count"}, 64'(got), 64'(total));
      @(negedge clk);
      ready = ($urandom_range(99) < pct);
      check_eq({tag, "_done"}, 64'(o_done), 64'd1);
      check_eq({tag, "_v_after"}, 64'(o_v), 64'd0);
      @(negedge clk);
      check_eq({tag, "_done_sticky"}, 64'(o_done), 64'd1);
      check_eq({tag, "_v_idle"}, 64'(o_v), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int target;
      int cyc;
      bit found;
      sel_b   = 1'b0;
      ready   = 1'b0;
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;

      // Full rate: one beat per cycle starting two cycles after release.
      reset_dut(1'b0);
      stream("a_full", 2, 4, 100, 1'b1);

      // Endpoint stalls the first beat for five cycles.
      reset_dut(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ready = 1'b0;
         check_eq("stall_v", 64'(o_v), 64'd1);
         check_eq("stall_core", 64'(o_core), 64'd0);
         check_eq("stall_addr", 64'(o_addr), 64'h2);
         check_eq("stall_data", o_data, 64'd1);
      end
      @(negedge clk);
      ready = 1'b1;
      check_eq("stall_release_core", 64'(o_core), 64'd0);
      @(negedge clk);
      check_eq("after_stall_v", 64'(o_v), 64'd1);
      check_eq("after_stall_core", 64'(o_core), 64'd1);
      check_eq("after_stall_addr", 64'(o_addr), 64'h2);
      check_eq("after_stall_data", o_data, 64'd1);

      // Random backpressure.
      reset_dut(1'b0);
      stream("a_rand", 2, 4, 50, 1'b0);

      // Reset pulse in the middle of tile 1's writes, then a clean restart.
      reset_dut(1'b0);
      target = ucode_on ? 'h8002 : 'h6;
      found  = 1'b0;
      cyc    = 0;
      while (!found && cyc < 200) begin
         @(negedge clk);
         cyc++;
         ready = 1'b1;
         if (o_v && o_core == 8'd1 && int'(o_addr) == target) found = 1'b1;
      end
      check_eq("mid_reset_target_seen", 64'(found), 64'd1);
      rst_n_a = 1'b0;
      @(negedge clk);
      check_eq("mid_reset_v", 64'(o_v), 64'd0);
      check_eq("mid_reset_done", 64'(o_done), 64'd0);
      rst_n_a = 1'b1;
      @(negedge clk);
      check_eq("mid_reset_v_release", 64'(o_v), 64'd0);
      stream("a_restart", 2, 4, 100, 1'b1);

      // Single tile, single ucode word.
      reset_dut(1'b1);
      stream("b_full", 1, 1, 100, 1'b1);
      reset_dut(1'b1);
      stream("b_rand", 1, 1, 50, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
